// File: rtl/lustre_unsigned_divmod_seq.sv
// Sequential unsigned divider: restoring division, one quotient bit per cycle,
// valid/ready handshakes on operand and result sides.
module lustre_unsigned_divmod_seq #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  r_reg;
  logic [N-1:0]  d_reg;
  logic          dbz_reg;
  logic [CW-1:0] count;

  logic [N:0]    trial;
  logic [N-1:0]  trial_diff;
  logic [N-1:0]  q_next;
  logic          ge;

  // The trial value keeps the bit shifted out of R, so the compare is N+1 wide;
  // when ge holds, the difference always fits in N bits, so mod-2^N subtraction is exact.
  always_comb begin
    trial      = {r_reg, q_reg[N-1]};
    ge         = !(trial < {1'b0, d_reg});
    trial_diff = trial[N-1:0] - d_reg;
  end

  generate
    if (N == 1) begin : g_q_one
      assign q_next = ge;
    end else begin : g_q_wide
      assign q_next = {q_reg[N-2:0], ge};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      dbz_reg <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_reg <= divisor;
            if (divisor == '0) begin
              q_reg   <= '1;
              r_reg   <= dividend;
              dbz_reg <= 1'b1;
              state   <= DONE;
            end else begin
              q_reg   <= dividend;
              r_reg   <= '0;
              dbz_reg <= 1'b0;
              count   <= CW'(N - 1);
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          r_reg <= ge ? trial_diff : trial[N-1:0];
          q_reg <= q_next;
          count <= count - CW'(1);
          if (count == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: doc/lustre_unsigned_divmod_seq.md
Name: lustre_unsigned_divmod_seq

Overview:
Multi-cycle unsigned divider for the Lustre stdlib. Produces quotient and remainder of two N-bit unsigned operands, one quotient bit per cycle, using restoring division. Each step is a partial-remainder versus divisor compare-and-subtract. The comparator's borrow/carry decision drives the step: when the comparator reports "not less than", the block subtracts. It serves as the sequential backend for Lustre `div`/`mod` on unsigned types. Valid/ready handshakes sit on both the input and output sides.

Parameters:
N, 8, operand/result width in bits (N >= 1)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block accepts operands this cycle
dividend  input  N  unsigned numerator
divisor  input  N  unsigned denominator
out_valid  output  1  result held stable
out_ready  input  1  consumer takes result this cycle
quotient  output  N  dividend / divisor
remainder  output  N  dividend mod divisor
div_by_zero  output  1  divisor was zero for this result

Behaviour:
- One clock. Reset is synchronous and active-high. While reset is high at a rising edge:
  - state <= IDLE
  - in_ready = 1, out_valid = 0
  - quotient, remainder, div_by_zero = 0
  - step counter = 0
- Reset mid-operation aborts the division. The result is discarded and never presented.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready = 1, out_valid = 0.
  - On in_valid & in_ready, latch dividend into Q and divisor into D. Clear R (N bits).
  - divisor != 0: counter <= N-1, go to BUSY.
  - divisor == 0: go straight to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
- BUSY: in_ready = 0, out_valid = 0. Each cycle performs one step:
  - T = {R, Q[N-1]} (N+1 bits).
  - ge = not (T < {1'b0, D}), unsigned compare of width N+1.
  - R <= ge ? (T - D) truncated to N bits : T[N-1:0].
  - Q <= {Q[N-2:0], ge}.
  - counter <= counter - 1. After the step taken with counter == 0, go to DONE.
- BUSY lasts exactly N cycles. For N = 1 it is a single cycle.
- DONE: out_valid = 1, quotient = Q, remainder = R. div_by_zero is 0 on the normal path.
  - Outputs are held stable while out_ready = 0. Backpressure may last indefinitely.
  - out_valid & out_ready at an edge -> IDLE.
  - in_ready is 0 in DONE, so there is no same-cycle reaccept. The next operation can be accepted one cycle after the handoff.
- Latency, accept edge to first out_valid cycle:
  - N+1 cycles for nonzero divisor.
  - 1 cycle for divide-by-zero.
- in_valid while not in IDLE is ignored. Operand inputs are sampled only on the accept edge; changes afterwards do not affect the result.
- Arithmetic:
  - All values are unsigned, with no sign extension.
  - The compare uses N+1 bits so the shifted-out MSB of R is never lost.
  - The subtraction result always fits in N bits when ge = 1.
- Invariants in DONE (nonzero divisor):
  - quotient*divisor + remainder == dividend
  - remainder < divisor
- div_by_zero = 1 together with out_valid in the zero case. It clears on the next accept.

Test Plan:
- N=8, reset held 2 cycles, then released -> in_ready=1, out_valid=0, quotient=remainder=0. Assert reset while in BUSY on 100/7 -> next cycle IDLE, and no out_valid ever appears for that operation.
- N=8, 100 / 7 accepted at cycle t -> out_valid rises at t+9 with quotient=14, remainder=2, div_by_zero=0.
- N=8, 200 / 0 -> out_valid at t+1 with quotient=255, remainder=200, div_by_zero=1.
- N=8, boundary operands, each returned with the stated quotient and remainder:
  - 255/1 -> q=255, r=0
  - 5/9 -> q=0, r=5
  - 255/255 -> q=1, r=0
  - 0/3 -> q=0, r=0
  - 128/128 -> q=1, r=0
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout. A new in_valid with 9/2 presented meanwhile is ignored. After the handoff, 9/2 is accepted in IDLE and yields q=4, r=1.
- N=1 exhaustive over all 4 operand pairs, plus N=8 random 10k ops checked against the reference model using the quotient*divisor + remainder == dividend invariant. Operands toggled during BUSY must not change any result.
